eight_bit_sipo_rx: RTL
======================

EIGHT_BIT_SIPO_RX -- requirements
Module: eight_bit_sipo_rx

Interface
REQ-001 Parameter: WIDTH, 8, byte width in bits; only 8 is supported.
REQ-002 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-low reset; reset=0 at a rising clock edge resets the block.
REQ-004 Port: sin  input  1  serial data bit.
REQ-005 Port: sin_valid  input  1  sin holds a valid bit this cycle.
REQ-006 Port: start  input  1  qualified by sin_valid; marks the first bit of a byte.
REQ-007 Port: dir  input  1  0 = MSB-first (shift-left producer); 1 = LSB-first (shift-right producer); sampled with the start bit.
REQ-008 Port: out_ready  input  1  consumer accepts out this cycle.
REQ-009 Port: clear_err  input  1  clears the sticky error flags.
REQ-010 Port: out  output  8  assembled byte.
REQ-011 Port: out_valid  output  1  out holds an unconsumed byte.
REQ-012 Port: busy  output  1  high while in SHIFT.
REQ-013 Port: overrun  output  1  sticky; a completed byte was dropped.
REQ-014 Port: framing_err  output  1  sticky; a frame was aborted by an early start.

Function
REQ-015 FSM has two states, IDLE and SHIFT; busy SHALL be 1 exactly in SHIFT.
REQ-016 IDLE: sin_valid=1 and start=1 captures sin as bit 1 of 8, latches dir, sets count=1, and moves to SHIFT; sin_valid=1 with start=0 is ignored.
REQ-017 SHIFT: each sin_valid=1 with start=0 captures one bit and increments count; cycles with sin_valid=0 hold all state, so gaps are unlimited.
REQ-018 MSB-first capture shifts the register left and inserts sin at bit 0; LSB-first capture shifts it right and inserts sin at bit 7.
REQ-019 Capture of the 8th bit completes the byte; the FSM returns to IDLE on the same edge, and count wraps to 0.
REQ-020 Latency: out and out_valid=1 SHALL appear on the edge that captures the 8th bit, i.e. visible the following cycle.
REQ-021 Handshake: a byte is consumed on any edge where out_valid=1 and out_ready=1; out_valid then falls unless a new byte loads on that edge.
REQ-022 Completion with out_valid=0, or with out_valid=1 and out_ready=1 on the same edge: the new byte loads into out, out_valid=1, and no error is raised.
REQ-023 Completion with out_valid=1 and out_ready=0: the new byte is dropped, out is unchanged, and overrun is set to 1.
REQ-024 SHIFT with sin_valid=1 and start=1: discard the partial byte, set framing_err=1, and treat the bit as a fresh first bit (count=1, dir re-latched).
REQ-025 out SHALL remain stable while out_valid=1 and no consume occurs.
REQ-026 clear_err=1 clears overrun and framing_err on the next edge; a same-edge set event takes priority over the clear.
REQ-027 A change to dir during SHIFT has no effect on the current frame.

Reset
REQ-028 reset=0 at a rising edge: FSM goes to IDLE, count=0, shift register=0, out=8'h00, out_valid=0, busy=0, overrun=0, framing_err=0.
REQ-029 Reset mid-frame discards the partial byte and any pending out without setting an error flag.
REQ-030 Reset overrides every other input on the same edge.

Structure
REQ-031 A shared package holds: WIDTH=8; state constants ST_IDLE and ST_SHIFT; DIR_MSB_FIRST=0 and DIR_LSB_FIRST=1.
REQ-032 One sub-module, sipo_shift_core, holds the 8-bit shift register, the direction-dependent shift and the 3-bit bit counter; the FSM, output buffer and flags stay in the top.

Verification
REQ-033 MSB-first: dir=0; send 0,1,0,1,0,1,0,1 with start on the first bit -> out=8'h55 and out_valid=1 the cycle after the 8th bit; busy=0.
REQ-034 LSB-first with gaps: dir=1; send the same bits with sin_valid=0 between bits -> out=8'hAA; overrun=0.
REQ-035 Backpressure: out_ready=0; send 8'h55 then 8'hAA -> out stays 8'h55 and overrun=1; clear_err=1 -> overrun=0.
REQ-036 Simultaneous consume/complete: out_valid=1 holding 8'h55; out_ready=1 on the edge that captures the 8th bit of 8'h0F -> out=8'h0F, out_valid=1, overrun=0.
REQ-037 Early start: start again after 3 bits, then send 8'hC3 MSB-first -> framing_err=1 and out=8'hC3.
REQ-038 Reset mid-frame: reset=0 after 5 bits -> all outputs are 0 and the FSM is in IDLE; the next full frame of 8'h81 yields out=8'h81.

Source files
------------

// File: rtl/eight_bit_sipo_rx_pkg.sv
// Shared constants and types for the eight-bit serial-to-parallel receiver.
package eight_bit_sipo_rx_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

    typedef logic [WIDTH-1:0] byte_t;

endpackage

// File: rtl/eight_bit_sipo_rx_if.sv
// Serial-in / byte-out bus; master is the serial producer plus byte consumer, slave is the receiver.
interface eight_bit_sipo_rx_if;
    import eight_bit_sipo_rx_pkg::*;

    logic  sin;
    logic  sin_valid;
    logic  start;
    logic  dir;
    logic  out_ready;
    logic  clear_err;
    byte_t out;
    logic  out_valid;
    logic  busy;
    logic  overrun;
    logic  framing_err;

    modport master (
        output sin, sin_valid, start, dir, out_ready, clear_err,
        input  out, out_valid, busy, overrun, framing_err
    );

    modport slave (
        input  sin, sin_valid, start, dir, out_ready, clear_err,
        output out, out_valid, busy, overrun, framing_err
    );

endinterface

// File: rtl/eight_bit_sipo_rx_sipo_shift_core.sv
// Shift register plus bit counter; o_next_data is the value the register takes on a capture,
// so the completed byte is available combinationally on the edge that captures bit 8.
module sipo_shift_core
    import eight_bit_sipo_rx_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       i_first,
    input  logic       i_shift,
    input  logic       i_dir,
    input  logic       i_sin,
    output byte_t      o_next_data,
    output logic       o_last
);

    byte_t            r_data;
    logic [CNT_W-1:0] r_count;
    logic             r_dir;

    logic             w_dir;
    byte_t            w_base;
    logic             w_capture;

    // A first bit starts from a cleared register with the freshly sampled direction.
    always_comb begin
        w_dir  = i_first ? i_dir : r_dir;
        w_base = i_first ? '0 : r_data;
        if (w_dir == DIR_MSB_FIRST) begin
            o_next_data = {w_base[WIDTH-2:0], i_sin};
        end else begin
            o_next_data = {i_sin, w_base[WIDTH-1:1]};
        end
    end

    assign w_capture = i_first | i_shift;
    assign o_last    = (r_count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_data  <= '0;
            r_count <= '0;
            r_dir   <= DIR_MSB_FIRST;
        end else if (w_capture) begin
            r_data  <= o_next_data;
            // The 3-bit counter wraps 7 -> 0 naturally on the completing bit.
            r_count <= i_first ? CNT_W'(1) : r_count + CNT_W'(1);
            if (i_first) begin
                r_dir <= i_dir;
            end
        end
    end

endmodule

// File: rtl/eight_bit_sipo_rx.sv
// Serial-to-parallel byte receiver: byte valid the cycle after its 8th bit is captured.
// One-deep output buffer; a byte completing while the buffer is full and not consumed is dropped (overrun).
module eight_bit_sipo_rx
    import eight_bit_sipo_rx_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic                clock,
    input  logic                reset,
    eight_bit_sipo_rx_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_framing_err;

    logic             w_first;
    logic             w_shift;
    logic             w_abort;
    logic             w_done;
    logic             w_last;
    logic             w_consume;
    logic             w_load;
    logic             w_drop;
    byte_t            w_next_data;

    sipo_shift_core u_core (
        .clock       (clock),
        .reset       (reset),
        .i_first     (w_first),
        .i_shift     (w_shift),
        .i_dir       (bus.dir),
        .i_sin       (bus.sin),
        .o_next_data (w_next_data),
        .o_last      (w_last)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_first      = 1'b0;
        w_shift      = 1'b0;
        w_abort      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.sin_valid && bus.start) begin
                    w_first      = 1'b1;
                    w_state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.sin_valid) begin
                    if (bus.start) begin
                        // Early start: restart the frame on this bit, remain in SHIFT.
                        w_first = 1'b1;
                        w_abort = 1'b1;
                    end else begin
                        w_shift = 1'b1;
                        if (w_last) begin
                            w_done       = 1'b1;
                            w_state_next = ST_IDLE;
                        end
                    end
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_consume = r_out_valid & bus.out_ready;
    assign w_load    = w_done & (~r_out_valid | bus.out_ready);
    assign w_drop    = w_done & r_out_valid & ~bus.out_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out       <= w_next_data;
            r_out_valid <= 1'b1;
        end else if (w_consume) begin
            r_out_valid <= 1'b0;
        end
    end

    // Set events win over a same-edge clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_overrun     <= 1'b0;
            r_framing_err <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (bus.clear_err) begin
                r_overrun <= 1'b0;
            end
            if (w_abort) begin
                r_framing_err <= 1'b1;
            end else if (bus.clear_err) begin
                r_framing_err <= 1'b0;
            end
        end
    end

    assign bus.out         = r_out;
    assign bus.out_valid   = r_out_valid;
    assign bus.busy        = (r_state == ST_SHIFT);
    assign bus.overrun     = r_overrun;
    assign bus.framing_err = r_framing_err;

endmodule
